// File: rtl/mult16_pkg.sv
// Shared widths and types for the 16x16 multiplier final-adder slice.
package mult16_pkg;
  localparam int MULT16_W         = 32;
  localparam int MULT16_SPLIT     = 16;
  localparam int MULT16_OVF_CNT_W = 16;

  typedef logic [MULT16_W-1:0]     prod_t;
  typedef logic [MULT16_SPLIT-1:0] half_t;
endpackage

// File: rtl/mult16_cpa_half.sv
// Combinational N-bit carry-propagate adder segment with carry in and carry out.
module mult16_cpa_half #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + (N+1)'(cin_i);
  assign sum_o  = full[N-1:0];
  assign cout_o = full[N];
endmodule

// File: rtl/mult16_cpa_pipe.sv
// Two-stage carry-propagate resolver: (sum, carry) -> product, with valid/ready
// on both sides and a saturating count of products that carried out of the top bit.
module mult16_cpa_pipe
  import mult16_pkg::*;
#(
  parameter int W     = MULT16_W,
  parameter int SPLIT = MULT16_SPLIT,
  parameter int CNT_W = MULT16_OVF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_prod,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int HW = W - SPLIT;

  logic             adv1, adv2;
  logic             s1_valid_q, s2_valid_q;
  logic [SPLIT-1:0] s1_lo_q;
  logic             s1_cmid_q;
  logic [HW-1:0]    s1_sum_hi_q, s1_carry_hi_q;
  logic [W-1:0]     prod_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HW-1:0]    hi_sum;
  logic             hi_cout;

  // Ready ripples back combinationally so a draining output frees both stages at once.
  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  mult16_cpa_half #(.N(SPLIT)) u_lo (
    .a_i    (in_sum[SPLIT-1:0]),
    .b_i    (in_carry[SPLIT-1:0]),
    .cin_i  (1'b0),
    .sum_o  (lo_sum),
    .cout_o (lo_cout)
  );

  mult16_cpa_half #(.N(HW)) u_hi (
    .a_i    (s1_sum_hi_q),
    .b_i    (s1_carry_hi_q),
    .cin_i  (s1_cmid_q),
    .sum_o  (hi_sum),
    .cout_o (hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_lo_q       <= lo_sum;
      s1_cmid_q     <= lo_cout;
      s1_sum_hi_q   <= in_sum[W-1:SPLIT];
      s1_carry_hi_q <= in_carry[W-1:SPLIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      ovf_q      <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        prod_q <= {hi_sum, s1_lo_q};
        ovf_q  <= hi_cout;
      end
    end
  end

  // Count delivered overflowing products, not stalled cycles; stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_prod  = prod_q;
  assign out_ovf   = ovf_q;
  assign ovf_count = cnt_q;
endmodule

// File: tb/tb_mult16_cpa_pipe.sv
// Randomized and directed bench for mult16_cpa_pipe against a queue-based reference.
module tb_mult16_cpa_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum, in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic        out_ovf;
  logic [15:0] ovf_count;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          n_acc = 0;
  int          n_drn = 0;
  bit          last_acc;
  bit          chk_lat = 0;
  logic [15:0] mcnt = 16'h0;

  mult16_cpa_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe handshakes at negedge, update model, advance past posedge.
  task automatic step();
    exp_t e;
    logic [32:0] full;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (!rst) begin
      chk("ovf_count", {48'h0, ovf_count}, {48'h0, mcnt});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else if (out_ready) begin
          e = q.pop_front();
          n_drn++;
          chk("prod", {32'h0, out_prod}, {32'h0, e.prod});
          chk("ovf", {63'h0, out_ovf}, {63'h0, e.ovf});
          if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
          if (e.ovf && mcnt != 16'hFFFF) mcnt++;
        end else begin
          chk("hold_prod", {32'h0, out_prod}, {32'h0, q[0].prod});
        end
      end
      if (in_valid && in_ready) begin
        full = {1'b0, in_sum} + {1'b0, in_carry};
        e.prod = full[31:0];
        e.ovf  = full[32];
        e.cyc  = cyc;
        q.push_back(e);
        n_acc++;
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] c);
    int t;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    t = 0;
    do begin
      step();
      t++;
    end while (!last_acc && t < 20);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic flush();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    chk("flush_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    q.delete();
    mcnt = 16'h0;
    rst = 1'b0;
  endtask

  initial begin
    int idx;
    logic [31:0] s, c;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b1;
    step();
    do_reset();
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_ovf_count", {48'h0, ovf_count}, 64'd0);
    chk("rst_out_prod", {32'h0, out_prod}, 64'd0);
    chk("rst_out_ovf", {63'h0, out_ovf}, 64'd0);

    // Directed vectors with latency checking.
    chk_lat = 1;
    send(32'hFFFE0000, 32'h00000001); flush();
    send(32'h0000FFFF, 32'h00000001); flush();
    send(32'h7FFFFFFF, 32'h00000001); flush();
    send(32'h80000000, 32'h80000000); flush();
    step();
    chk("ovf_count_one", {48'h0, ovf_count}, 64'd1);

    // Backpressure: six stalled cycles, pairs yielding 1..4.
    chk_lat = 0;
    out_ready = 1'b0;
    idx = 1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (idx <= 4);
      in_sum = 32'(idx - 1);
      in_carry = 32'h1;
      if (i >= 2) chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
      step();
      if (last_acc) idx++;
    end
    chk("bp_accepted", 64'(n_acc), 64'd2);
    chk("bp_hold_one", {32'h0, out_prod}, 64'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = (idx <= 4);
      in_sum = 32'(idx - 1);
      in_carry = 32'h1;
      chk("bp_no_gap", {63'h0, out_valid}, 64'd1);
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_out", 64'(q.size()), 64'd0);

    // Random back-to-back streaming.
    chk_lat = 1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      in_sum = $urandom;
      in_carry = $urandom;
      chk("stream_in_ready", {63'h0, in_ready}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    flush();

    // Drive the counter into saturation, then past it.
    in_valid = 1'b1;
    in_sum = 32'h80000000;
    in_carry = 32'h80000000;
    while (mcnt != 16'hFFFF && cyc < 90000) step();
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    flush();
    step();
    chk("ovf_sat", {48'h0, ovf_count}, 64'hFFFF);

    // Reset with two pairs in flight.
    in_valid = 1'b1;
    s = $urandom; c = $urandom;
    in_sum = s; in_carry = c;
    step();
    in_sum = ~s; in_carry = c;
    step();
    do_reset();
    chk("mid_rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("mid_rst_ovf_count", {48'h0, ovf_count}, 64'd0);
    for (int i = 0; i < 4; i++) step();
    send(32'h12345678, 32'h0F0F0F0F);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
